cordic_fm_discriminator: RTL and testbench

//  Post-CORDIC stage. Consumes the magnitude/phase stream of the rectangular-to-polar

---
 rtl/cordic_fm_discriminator_if.sv | 28 ++
 rtl/cordic_fm_discriminator.sv | 109 ++++++++++
 tb/tb_cordic_fm_discriminator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_fm_discriminator_if.sv
`default_nettype none
// ============================================================================
// Module  : cordic_fm_discriminator_if
// Purpose : Polar sample stream in, decimated frequency estimate out.
// Rev     : 1.0
// ============================================================================
interface cordic_fm_discriminator_if #(
  parameter int W = 7,
  parameter int L = 2
);
  logic                  in_valid;
  logic [W:0]            r;
  logic signed [W+1:0]   phi;
  logic signed [W+L+1:0] freq;
  logic                  out_valid;
  logic                  squelch;

  modport master (
    output in_valid, r, phi,
    input  freq, out_valid, squelch
  );

  modport slave (
    input  in_valid, r, phi,
    output freq, out_valid, squelch
  );
endinterface
`default_nettype wire

// File: rtl/cordic_fm_discriminator.sv
`default_nettype none
// ============================================================================
// Module  : cordic_fm_discriminator
// Purpose : Wrapped phase-difference accumulator over 2^L samples, with squelch.
// Rev     : 1.0
// ============================================================================
module cordic_fm_discriminator #(
  parameter int W    = 7,
  parameter int L    = 2,
  parameter int RMIN = 8
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 clr,
  cordic_fm_discriminator_if.slave  bus
);

  localparam logic signed [W+2:0] C_P180 = (W+3)'(180);
  localparam logic signed [W+2:0] C_N180 = -C_P180;
  localparam logic signed [W+2:0] C_360  = (W+3)'(360);
  localparam logic [W:0]          C_RMIN = (W+1)'(RMIN);

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                r_state;
  logic signed [W+1:0]   r_prev_phi;
  logic [L-1:0]          r_count;
  logic signed [W+L+1:0] r_acc;
  logic signed [W+L+1:0] r_freq;
  logic                  r_sq_acc;
  logic                  r_squelch;
  logic                  r_out_valid;

  logic                  w_good;
  logic                  w_last;
  logic signed [W+2:0]   w_raw;
  logic signed [W+1:0]   w_d;
  logic signed [W+L+1:0] w_sum;

  assign w_good = (bus.r >= C_RMIN);
  assign w_last = (r_count == {L{1'b1}});
  assign w_raw  = {bus.phi[W+1], bus.phi} - {r_prev_phi[W+1], r_prev_phi};

  // Only a good sample with a held reference yields a nonzero difference;
  // +/-180 exactly are left as-is.
  always_comb begin
    w_d = '0;
    if (w_good && (r_state == ST_RUN)) begin
      if (w_raw > C_P180)
        w_d = (W+2)'(w_raw - C_360);
      else if (w_raw < C_N180)
        w_d = (W+2)'(w_raw + C_360);
      else
        w_d = (W+2)'(w_raw);
    end
  end

  assign w_sum = r_acc + {{L{w_d[W+1]}}, w_d};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_PRIME;
      r_prev_phi  <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_freq      <= '0;
      r_sq_acc    <= 1'b0;
      r_squelch   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (clr) begin
        r_count  <= '0;
        r_acc    <= '0;
        r_sq_acc <= 1'b0;
        r_state  <= ST_PRIME;
      end else if (bus.in_valid) begin
        // A squelched sample drops the reference; the next good one re-primes.
        if (w_good) begin
          r_prev_phi <= bus.phi;
          r_state    <= ST_RUN;
        end else begin
          r_state    <= ST_PRIME;
        end
        if (w_last) begin
          r_freq      <= w_sum;
          r_squelch   <= r_sq_acc | ~w_good;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_sq_acc    <= 1'b0;
          r_count     <= '0;
        end else begin
          r_acc       <= w_sum;
          r_sq_acc    <= r_sq_acc | ~w_good;
          r_count     <= r_count + L'(1);
        end
      end
    end
  end

  assign bus.freq      = r_freq;
  assign bus.out_valid = r_out_valid;
  assign bus.squelch   = r_squelch;

endmodule
`default_nettype wire

// File: tb/tb_cordic_fm_discriminator.sv
`default_nettype none
// ============================================================================
// Module  : tb_cordic_fm_discriminator
// Purpose : Directed and random stimulus against an integer reference model.
// Rev     : 1.0
// ============================================================================
module tb_cordic_fm_discriminator;

  localparam int W    = 7;
  localparam int L    = 2;
  localparam int RMIN = 8;
  localparam int N    = 1 << L;

  logic clk;
  logic reset_n;
  logic clr;

  cordic_fm_discriminator_if #(.W(W), .L(L)) bus ();

  cordic_fm_discriminator #(.W(W), .L(L), .RMIN(RMIN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state, plain integers
  bit m_primed;
  int m_prev;
  int m_cnt;
  int m_acc;
  bit m_sq_acc;
  int m_freq;
  bit m_ov;
  bit m_sq_out;

  function automatic int wrap(input int x);
    int y = x;
    while (y > 180)  y -= 360;
    while (y < -180) y += 360;
    return y;
  endfunction

  task automatic model_reset();
    m_primed = 0; m_prev = 0; m_cnt = 0; m_acc = 0;
    m_sq_acc = 0; m_freq = 0; m_ov = 0; m_sq_out = 0;
  endtask

  task automatic model_edge(input bit vld, input int rr, input int pp, input bit cl);
    int d;
    m_ov = 0;
    if (cl) begin
      m_cnt = 0; m_acc = 0; m_sq_acc = 0; m_primed = 0;
    end else if (vld) begin
      d = 0;
      if (rr >= RMIN) begin
        if (m_primed) d = wrap(pp - m_prev);
        m_prev   = pp;
        m_primed = 1;
      end else begin
        m_primed = 0;
        m_sq_acc = 1;
      end
      m_acc += d;
      m_cnt++;
      if (m_cnt == N) begin
        m_freq   = m_acc;
        m_sq_out = m_sq_acc;
        m_ov     = 1;
        m_acc = 0; m_sq_acc = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ov"},   {31'b0, bus.out_valid}, {31'b0, m_ov});
    chk({tag, "_freq"}, $signed(bus.freq),      m_freq);
    chk({tag, "_sq"},   {31'b0, bus.squelch},   {31'b0, m_sq_out});
  endtask

  task automatic chk_now(input string tag, input int f, input bit s);
    chk({tag, "_ov_const"},   {31'b0, bus.out_valid}, 1);
    chk({tag, "_freq_const"}, $signed(bus.freq),      f);
    chk({tag, "_sq_const"},   {31'b0, bus.squelch},   {31'b0, s});
  endtask

  // Check results of the previous edge, then drive the next one's inputs
  task automatic cyc(input string tag, input bit vld, input int rr, input int pp,
                     input bit cl);
    @(negedge clk);
    check_outputs(tag);
    bus.in_valid = vld;
    bus.r        = rr[W:0];
    bus.phi      = pp[W+1:0];
    clr          = cl;
    model_edge(vld, rr, pp, cl);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int rr;
    int pp;
    bit vld;
    bit cl;

    bus.in_valid = 1'b0;
    bus.r        = '0;
    bus.phi      = '0;
    clr          = 1'b0;
    reset_n      = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("init_rst");
    reset_n = 1'b1;
    model_edge(0, 0, 0, 0);

    // Scenario 1: reset mid-block
    for (int i = 0; i < 7; i++) cyc("s1_pre", 1'b1, 100, 10 * i, 1'b0);
    @(negedge clk);
    check_outputs("s1_pre_rst");
    bus.in_valid = 1'b0;
    clr          = 1'b0;
    reset_n      = 1'b0;
    #1;
    model_reset();
    check_outputs("s1_rst_async");
    chk("s1_rst_freq_zero", $signed(bus.freq), 0);
    @(negedge clk);
    check_outputs("s1_rst_hold");
    reset_n = 1'b1;
    model_edge(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("s1", 1'b1, 100, 10 * i, 1'b0);
    idle("s1_end");
    chk_now("s1", 30, 1'b0);

    // Scenario 2: continuous tone
    cyc("s2_clr", 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc("s2", 1'b1, 100, 10 * i, 1'b0);
      if (i == 4) chk_now("s2_b1", 30, 1'b0);
    end
    idle("s2_end");
    chk_now("s2_b2", 40, 1'b0);

    // Scenario 3: wrap-around
    cyc("s3_clr", 1'b0, 0, 0, 1'b1);
    cyc("s3a", 1'b1, 100, 170, 1'b0);
    cyc("s3a", 1'b1, 100, -170, 1'b0);
    cyc("s3a", 1'b1, 100, 170, 1'b0);
    cyc("s3a", 1'b1, 100, -170, 1'b0);
    idle("s3a_end");
    chk_now("s3a", 20, 1'b0);
    cyc("s3_clr2", 1'b0, 0, 0, 1'b1);
    cyc("s3b", 1'b1, 100, 0, 1'b0);
    cyc("s3b", 1'b1, 100, 180, 1'b0);
    cyc("s3b", 1'b1, 100, 0, 1'b0);
    cyc("s3b", 1'b1, 100, -180, 1'b0);
    idle("s3b_end");
    chk_now("s3b", -180, 1'b0);

    // Scenario 4: squelch on 3rd sample
    cyc("s4_clr", 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc("s4", 1'b1, (i == 2) ? 5 : 100, 10 * i, 1'b0);
      if (i == 4) chk_now("s4_b1", 10, 1'b1);
    end
    idle("s4_end");
    chk_now("s4_b2", 40, 1'b0);

    // Scenario 5: clr coincident with a sample
    cyc("s5_clr", 1'b0, 0, 0, 1'b1);
    cyc("s5", 1'b1, 100, 40, 1'b0);
    cyc("s5_drop", 1'b1, 100, 45, 1'b1);
    for (int i = 0; i < 4; i++) cyc("s5", 1'b1, 100, 50 + 10 * i, 1'b0);
    idle("s5_end");
    chk_now("s5", 30, 1'b0);

    // Scenario 6: gapped tone
    cyc("s6_clr", 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc("s6", 1'b1, 100, 10 * i, 1'b0);
      idle("s6_gap1");
      if (i == 3) chk_now("s6_b1", 30, 1'b0);
      if (i == 7) chk_now("s6_b2", 40, 1'b0);
      idle("s6_gap2");
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      vld = ($urandom_range(3) != 0);
      cl  = ($urandom_range(31) == 0);
      rr  = ($urandom_range(9) == 0) ? int'($urandom_range(RMIN - 1))
                                     : int'($urandom_range(255, RMIN));
      pp  = int'($urandom_range(359)) - 180;
      cyc("rnd", vld, rr, pp, cl);
    end
    idle("final");
    idle("final2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
